pipelined_barrel_shifter: RTL and testbench

//  - Parametrised successor to the team's 4-bit rotator: WIDTH-bit, log2-staged shifter/rotator with

---
 rtl/barrel_shift_pkg.sv | 20 ++
 rtl/barrel_shift_stage.sv | 119 +++++++++++
 rtl/pipelined_barrel_shifter.sv | 85 ++++++++
 tb/tb_pipelined_barrel_shifter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_shift_pkg.sv
// Shared opcode encoding and decode helpers for the pipelined barrel shifter.
package barrel_shift_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_ROL = 3'b000;
    localparam logic [OP_W-1:0] OP_ROR = 3'b001;
    localparam logic [OP_W-1:0] OP_SLL = 3'b010;
    localparam logic [OP_W-1:0] OP_SRL = 3'b011;
    localparam logic [OP_W-1:0] OP_SRA = 3'b100;

    function automatic logic is_right_op(input logic [OP_W-1:0] op);
        return (op == OP_ROR) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic logic is_reserved_op(input logic [OP_W-1:0] op);
        return op > OP_SRA;
    endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One log2 stage: left shift/rotate by DIST when its amount bit is set, with an optional
// valid/data register and the local ready term of the elastic chain.
module barrel_shift_stage
    import barrel_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIST  = 1,
    parameter int unsigned SHW   = 3,
    parameter bit          REG   = 1'b1,
    parameter bit          LAST  = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   amt_i,
    input  logic [OP_W-1:0]  op_i,
    input  logic             sign_i,
    input  logic             err_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic [SHW-1:0]   amt_o,
    output logic [OP_W-1:0]  op_o,
    output logic             sign_o,
    output logic             err_o,
    output logic             zero_o
);

    localparam int unsigned AmtBit = $clog2(DIST);

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            bit_rev[i] = x[WIDTH-1-i];
        end
    endfunction

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] result;
    logic             fill;

    // Right ops arrive bit-reversed, so SRA fills the low end with the original sign bit.
    always_comb begin
        fill    = (op_i == OP_SRA) ? sign_i : 1'b0;
        shifted = data_i;
        if (amt_i[AmtBit]) begin
            if ((op_i == OP_ROL) || (op_i == OP_ROR)) begin
                shifted = {data_i[WIDTH-DIST-1:0], data_i[WIDTH-1:WIDTH-DIST]};
            end else begin
                shifted = {data_i[WIDTH-DIST-1:0], {DIST{fill}}};
            end
        end
        result = shifted;
        if (LAST && is_right_op(op_i)) begin
            result = bit_rev(shifted);
        end
    end

    if (REG) begin : g_reg
        logic             valid_q;
        logic [WIDTH-1:0] data_q;
        logic [SHW-1:0]   amt_q;
        logic [OP_W-1:0]  op_q;
        logic             sign_q;
        logic             err_q;
        logic             zero_q;
        logic             load;

        assign ready_o = !valid_q || ready_i;
        assign load    = valid_i && ready_o;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                amt_q   <= '0;
                op_q    <= OP_ROL;
                sign_q  <= 1'b0;
                err_q   <= 1'b0;
                zero_q  <= 1'b0;
            end else begin
                if (ready_o) begin
                    valid_q <= valid_i;
                end
                // Payload only moves on a real transfer so a stalled output stays stable.
                if (load) begin
                    data_q <= result;
                    amt_q  <= amt_i;
                    op_q   <= op_i;
                    sign_q <= sign_i;
                    err_q  <= err_i;
                    zero_q <= (result == '0);
                end
            end
        end

        assign valid_o = valid_q;
        assign data_o  = data_q;
        assign amt_o   = amt_q;
        assign op_o    = op_q;
        assign sign_o  = sign_q;
        assign err_o   = err_q;
        assign zero_o  = zero_q;
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_i;

        assign ready_o = ready_i;
        assign valid_o = valid_i;
        assign data_o  = result;
        assign amt_o   = amt_i;
        assign op_o    = op_i;
        assign sign_o  = sign_i;
        assign err_o   = err_i;
        assign zero_o  = (result == '0);
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// WIDTH-bit streaming shifter/rotator built from SHW log2 stages on a single left-shift
// datapath; right ops are bit-reversed on entry and restored in the last stage.
module pipelined_barrel_shifter
    import barrel_shift_pkg::*;
#(
    parameter int unsigned   WIDTH    = 8,
    parameter bit            PIPE_ALL = 1'b1,
    localparam int unsigned  SHW      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_err
);

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            bit_rev[i] = x[WIDTH-1-i];
        end
    endfunction

    logic [SHW:0]     v;
    logic [SHW:0]     r;
    logic [WIDTH-1:0] d [SHW+1];
    logic [SHW-1:0]   a [SHW+1];
    logic [OP_W-1:0]  o [SHW+1];
    logic [SHW:0]     s;
    logic [SHW:0]     e;
    logic [SHW-1:0]   z;

    // Reserved ops travel with a zero amount so every stage passes them through.
    assign v[0]   = in_valid;
    assign in_ready = r[0];
    assign d[0]   = is_right_op(in_op) ? bit_rev(in_data) : in_data;
    assign a[0]   = is_reserved_op(in_op) ? '0 : in_amt;
    assign o[0]   = in_op;
    assign s[0]   = in_data[WIDTH-1];
    assign e[0]   = is_reserved_op(in_op);
    assign r[SHW] = out_ready;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        barrel_shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k),
            .SHW   (SHW),
            .REG   (PIPE_ALL || (k == SHW - 1)),
            .LAST  (k == SHW - 1)
        ) u_stage (
            .clk_i   (clk),
            .rst_i   (rst),
            .valid_i (v[k]),
            .ready_o (r[k]),
            .data_i  (d[k]),
            .amt_i   (a[k]),
            .op_i    (o[k]),
            .sign_i  (s[k]),
            .err_i   (e[k]),
            .valid_o (v[k+1]),
            .ready_i (r[k+1]),
            .data_o  (d[k+1]),
            .amt_o   (a[k+1]),
            .op_o    (o[k+1]),
            .sign_o  (s[k+1]),
            .err_o   (e[k+1]),
            .zero_o  (z[k])
        );
    end

    assign out_valid = v[SHW];
    assign out_data  = d[SHW];
    assign out_err   = e[SHW];
    assign out_zero  = z[SHW-1];

    logic unused_tail;
    assign unused_tail = ^{a[SHW], o[SHW], s[SHW], z[SHW-2:0]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench: two shifters (fully pipelined and single-register) driven with directed
// vectors; a negedge monitor pops expected results as each output transfer occurs.
module tb_pipelined_barrel_shifter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst, in_valid, in_ready, out_valid, out_ready, out_zero, out_err;
    logic [7:0] in_data  [2];
    logic [7:0] out_data [2];
    logic [2:0] in_amt   [2];
    logic [2:0] in_op    [2];

    pipelined_barrel_shifter #(.WIDTH(8), .PIPE_ALL(1'b1)) u_dut_pipe (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_amt(in_amt[0]), .in_op(in_op[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_zero(out_zero[0]), .out_err(out_err[0])
    );

    pipelined_barrel_shifter #(.WIDTH(8), .PIPE_ALL(1'b0)) u_dut_flat (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_amt(in_amt[1]), .in_op(in_op[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_zero(out_zero[1]), .out_err(out_err[1])
    );

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         acc;
        bit         lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   first_pop = -1;
    int   last_pop = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] a,
                                         input logic [2:0] op);
        logic [15:0] t;
        case (op)
            3'd0: begin t = {d, d} << a; return t[15:8]; end
            3'd1: begin t = {d, d} >> a; return t[7:0]; end
            3'd2: return d << a;
            3'd3: return d >> a;
            3'd4: return 8'($signed(d) >>> a);
            default: return d;
        endcase
    endfunction

    function automatic int qsize(input int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction

    task automatic check_out(input int u);
        exp_t e;
        if (qsize(u) == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dut%0d unexpected output: got %h, want none", u, out_data[u]);
            return;
        end
        if (u == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        cmp($sformatf("dut%0d result {err,zero,data}", u),
            32'({out_err[u], out_zero[u], out_data[u]}),
            32'({e.err, e.data == 8'h00, e.data}));
        if (e.lat) cmp($sformatf("dut%0d latency", u), cyc - e.acc, (u == 0) ? 3 : 1);
        if (u == 0) begin
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
    endtask

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst[u] && out_valid[u] && out_ready[u]) check_out(u);
        end
    end

    task automatic push(input int u, input logic [7:0] expd, input logic [2:0] op, input bit lat);
        exp_t e;
        e.data = expd;
        e.err  = (op > 3'd4);
        e.acc  = cyc;
        e.lat  = lat;
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Holds the operand until accepted; leaves in_valid high for back-to-back issue.
    task automatic send(input int u, input logic [7:0] d, input logic [2:0] a,
                        input logic [2:0] op, input logic [7:0] expd, input bit lat = 1'b0);
        in_valid[u] = 1'b1;
        in_data[u]  = d;
        in_amt[u]   = a;
        in_op[u]    = op;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready[u]) begin
                push(u, expd, op, lat);
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL dut%0d send timeout: got in_ready=0, want 1", u);
        in_valid[u] = 1'b0;
    endtask

    task automatic drain(input int u);
        in_valid[u] = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (qsize(u) == 0) return;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL dut%0d drain timeout: got %0d pending, want 0", u, qsize(u));
    endtask

    task automatic reset_test(input int u, input int cap);
        out_ready[u] = 1'b0;
        for (int i = 0; i < cap; i++) send(u, 8'(8'h11 * (i + 1)), 3'd0, 3'd0, 8'(8'h11 * (i + 1)));
        in_valid[u] = 1'b0;
        @(posedge clk);
        #1;
        cmp($sformatf("dut%0d full before rst", u), 32'(in_ready[u]), 32'(0));
        rst[u] = 1'b1;
        @(posedge clk);
        #1;
        cmp($sformatf("dut%0d rst out_valid", u), 32'(out_valid[u]), 32'(0));
        cmp($sformatf("dut%0d rst out_data", u), 32'(out_data[u]), 32'(0));
        if (u == 0) q0.delete();
        else        q1.delete();
        rst[u]       = 1'b0;
        out_ready[u] = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            cmp($sformatf("dut%0d no stale after rst", u), 32'(out_valid[u]), 32'(0));
        end
        @(posedge clk);
        #1;
        send(u, 8'hB1, 3'd3, 3'd0, 8'h8D, 1'b1);
        drain(u);
    endtask

    logic [7:0] bp_d   [5] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    logic [2:0] bp_a   [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [2:0] bp_op  [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [7:0] bp_exp [5] = '{8'h24, 8'h0D, 8'hB0, 8'h07, 8'hFC};

    initial begin
        logic [7:0] held;
        logic [7:0] rd;
        logic [2:0] ra, rop;
        int         idx;

        rst       = 2'b11;
        in_valid  = 2'b00;
        out_ready = 2'b11;
        for (int u = 0; u < 2; u++) begin
            in_data[u] = 8'h00;
            in_amt[u]  = 3'd0;
            in_op[u]   = 3'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            cmp($sformatf("dut%0d reset out_valid", u), 32'(out_valid[u]), 32'(0));
            cmp($sformatf("dut%0d reset out_data", u), 32'(out_data[u]), 32'(0));
            cmp($sformatf("dut%0d reset out_zero", u), 32'(out_zero[u]), 32'(0));
            cmp($sformatf("dut%0d reset out_err", u), 32'(out_err[u]), 32'(0));
        end
        rst = 2'b00;
        @(posedge clk);
        #1;
        cmp("dut0 in_ready after rst", 32'(in_ready[0]), 32'(1));
        cmp("dut1 in_ready after rst", 32'(in_ready[1]), 32'(1));

        // Directed vectors, fully pipelined.
        send(0, 8'hB1, 3'd3, 3'd0, 8'h8D, 1'b1);
        drain(0);
        send(0, 8'hB1, 3'd1, 3'd1, 8'hD8);
        for (int op = 0; op < 5; op++) send(0, 8'hB1, 3'd0, 3'(op), 8'hB1);
        send(0, 8'hFF, 3'd7, 3'd2, 8'h80);
        send(0, 8'hFF, 3'd7, 3'd3, 8'h01);
        send(0, 8'h90, 3'd2, 3'd4, 8'hE4);
        send(0, 8'h70, 3'd2, 3'd4, 8'h1C);
        send(0, 8'h5A, 3'd3, 3'd6, 8'h5A);
        send(0, 8'h01, 3'd1, 3'd3, 8'h00);
        drain(0);

        // Back-to-back stream: one result per cycle.
        first_pop = -1;
        for (int i = 0; i < 16; i++) begin
            rd  = 8'($urandom);
            ra  = 3'($urandom_range(0, 7));
            rop = 3'($urandom_range(0, 4));
            send(0, rd, ra, rop, model(rd, ra, rop));
        end
        drain(0);
        cmp("dut0 throughput span", last_pop - first_pop, 15);

        // Backpressure: six stalled cycles offering five ops.
        out_ready[0] = 1'b0;
        idx  = 0;
        held = 8'h00;
        for (int c = 0; c < 6; c++) begin
            in_valid[0] = (idx < 5);
            if (idx < 5) begin
                in_data[0] = bp_d[idx];
                in_amt[0]  = bp_a[idx];
                in_op[0]   = bp_op[idx];
            end
            @(negedge clk);
            if (in_valid[0] && in_ready[0]) begin
                push(0, bp_exp[idx], bp_op[idx], 1'b0);
                idx++;
            end
            if (c == 3) held = out_data[0];
            @(posedge clk);
            #1;
        end
        cmp("bp accepted", idx, 3);
        cmp("bp in_ready", 32'(in_ready[0]), 32'(0));
        cmp("bp out_valid held", 32'(out_valid[0]), 32'(1));
        cmp("bp out_data stable", 32'(out_data[0]), 32'(held));
        cmp("bp head value", 32'(out_data[0]), 32'(8'h24));
        out_ready[0] = 1'b1;
        for (int i = 3; i < 5; i++) send(0, bp_d[i], bp_a[i], bp_op[i], bp_exp[i]);
        drain(0);

        reset_test(0, 3);

        // Single-register variant.
        send(1, 8'hB1, 3'd3, 3'd0, 8'h8D, 1'b1);
        drain(1);
        send(1, 8'h90, 3'd2, 3'd4, 8'hE4);
        send(1, 8'h3C, 3'd5, 3'd7, 8'h3C);
        send(1, 8'h01, 3'd1, 3'd3, 8'h00);
        drain(1);
        reset_test(1, 1);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
